// File: rtl/sd_pad_bank.sv
// sd_pad_bank: registered bidirectional pad bank for the SD CMD/DAT lines with
// bus-turnaround sequencing, per-transfer open-drain drive and an input synchroniser.
//
// state   | meaning
// --------+------------------------------------------------------------
// RX      | lines released, remote side may drive, rx_rdy asserted
// TURN_TX | high-Z gap before this bank takes the lines
// DRIVE   | bank drives the output register, drv_gnt asserted
// PARK    | one cycle of all ones (driven push-pull, released open-drain)
// TURN_RX | high-Z gap before the remote side may drive
module sd_pad_bank #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TURNAROUND  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe_req,
    input  logic             od_mode,
    input  logic [WIDTH-1:0] out_data,
    output logic             drv_gnt,
    output logic             rx_rdy,
    output logic [WIDTH-1:0] in_data,
    inout  wire  [WIDTH-1:0] io
);

    typedef enum logic [2:0] {
        RX      = 3'd0,
        TURN_TX = 3'd1,
        DRIVE   = 3'd2,
        PARK    = 3'd3,
        TURN_RX = 3'd4
    } state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND - 1);

    state_t                              state_q, state_d;
    logic [3:0]                          cnt_q, cnt_d;
    logic [WIDTH-1:0]                    out_q, out_d;
    logic                                od_q, od_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q, sync_d;
    logic                                drive_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX;
            cnt_q   <= 4'd0;
            out_q   <= '1;
            od_q    <= 1'b0;
            sync_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            od_q    <= od_d;
            sync_q  <= sync_d;
        end
    end

    // Output register idles at all ones so DRIVE always opens with a recessive word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = '1;
        unique case (state_q)
            RX: begin
                if (oe_req) begin
                    state_d = TURN_TX;
                    cnt_d   = TURN_LOAD;
                end
            end
            TURN_TX: begin
                if (!oe_req) begin
                    state_d = RX;
                end else if (cnt_q == 4'd0) begin
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DRIVE: begin
                if (oe_req) begin
                    out_d = out_data;
                end else begin
                    state_d = PARK;
                end
            end
            PARK: begin
                state_d = TURN_RX;
                cnt_d   = TURN_LOAD;
            end
            TURN_RX: begin
                if (cnt_q == 4'd0) begin
                    state_d = RX;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RX;
            end
        endcase
    end

    always_comb begin
        od_d   = od_mode;
        sync_d = {sync_q[SYNC_STAGES-2:0], io};
    end

    assign drive_en = (state_q == DRIVE) || (state_q == PARK);
    assign drv_gnt  = (state_q == DRIVE);
    assign rx_rdy   = (state_q == RX);
    assign in_data  = sync_q[SYNC_STAGES-1];

    // Open-drain only ever pulls low; a one is left to the external pull-up.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign io[i] = (drive_en && !(od_q && out_q[i])) ? out_q[i] : 1'bz;
    end

endmodule

// File: tb/tb_sd_pad_bank.sv
// Directed self-checking bench for sd_pad_bank: a WIDTH=4/TURNAROUND=2 bank for the
// main sequences and a TURNAROUND=3 bank for the turnaround abort case.
module tb_sd_pad_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       oe_req = 1'b0;
    logic       oe_req3 = 1'b0;
    logic       od_mode = 1'b0;
    logic [3:0] out_data = 4'b0000;
    logic [3:0] ext_oe = 4'b1111;
    logic [3:0] ext_val = 4'b0000;
    logic [3:0] ext_oe3 = 4'b0000;
    logic [3:0] ext_val3 = 4'b0000;

    logic       drv_gnt, rx_rdy, drv_gnt3, rx_rdy3;
    logic [3:0] in_data, in_data3;
    tri1  [3:0] io;
    tri1  [3:0] io3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_ext
        assign io[g]  = ext_oe[g]  ? ext_val[g]  : 1'bz;
        assign io3[g] = ext_oe3[g] ? ext_val3[g] : 1'bz;
    end

    sd_pad_bank #(.WIDTH(4), .SYNC_STAGES(2), .TURNAROUND(2)) u_dut (
        .clk(clk), .rst(rst), .oe_req(oe_req), .od_mode(od_mode), .out_data(out_data),
        .drv_gnt(drv_gnt), .rx_rdy(rx_rdy), .in_data(in_data), .io(io)
    );

    sd_pad_bank #(.WIDTH(4), .SYNC_STAGES(2), .TURNAROUND(3)) u_dut3 (
        .clk(clk), .rst(rst), .oe_req(oe_req3), .od_mode(od_mode), .out_data(out_data),
        .drv_gnt(drv_gnt3), .rx_rdy(rx_rdy3), .in_data(in_data3), .io(io3)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        ext_oe = 4'b1111; ext_val = 4'b0000; rst = 1'b1;
        tick; tick;
        checks++; if (drv_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", drv_gnt); end
        checks++; if (rx_rdy !== 1'b1) begin errors++; $display("FAIL rst_rx_rdy got %b exp 1", rx_rdy); end
        checks++; if (rx_rdy3 !== 1'b1) begin errors++; $display("FAIL rst_rx_rdy3 got %b exp 1", rx_rdy3); end
        checks++; if (io !== 4'b0000) begin errors++; $display("FAIL rst_io_z got %b exp 0000", io); end
        checks++; if (in_data !== 4'b1111) begin errors++; $display("FAIL rst_in_data got %b exp 1111", in_data); end
        rst = 1'b0;
        tick;
        checks++; if (in_data !== 4'b1111) begin errors++; $display("FAIL sync_edge1 got %b exp 1111", in_data); end
        tick;
        checks++; if (in_data !== 4'b0000) begin errors++; $display("FAIL sync_edge2 got %b exp 0000", in_data); end
        ext_oe = 4'b0000;
        #1;
    endtask

    task automatic test_grant;
        oe_req = 1'b1; out_data = 4'b1010;
        for (int i = 1; i <= 2; i++) begin
            tick;
            checks++; if (drv_gnt !== 1'b0) begin errors++; $display("FAIL grant_early edge %0d got %b exp 0", i, drv_gnt); end
            checks++; if (rx_rdy !== 1'b0) begin errors++; $display("FAIL turn_tx_rx_rdy edge %0d got %b exp 0", i, rx_rdy); end
            checks++; if (io !== 4'b1111) begin errors++; $display("FAIL turn_tx_io edge %0d got %b exp 1111", i, io); end
        end
        tick;
        checks++; if (drv_gnt !== 1'b1) begin errors++; $display("FAIL grant_edge3 got %b exp 1", drv_gnt); end
        checks++; if (io !== 4'b1111) begin errors++; $display("FAIL first_drive_io got %b exp 1111", io); end
        tick;
        checks++; if (io !== 4'b1010) begin errors++; $display("FAIL drive_1010 got %b exp 1010", io); end
        out_data = 4'b0011;
        tick;
        checks++; if (io !== 4'b0011) begin errors++; $display("FAIL drive_0011 got %b exp 0011", io); end
        tick;
        checks++; if (in_data !== 4'b1010) begin errors++; $display("FAIL loopback got %b exp 1010", in_data); end
    endtask

    task automatic test_release;
        oe_req = 1'b0;
        tick;
        checks++; if (drv_gnt !== 1'b0) begin errors++; $display("FAIL park_gnt got %b exp 0", drv_gnt); end
        checks++; if (io !== 4'b1111) begin errors++; $display("FAIL park_io got %b exp 1111", io); end
        checks++; if (rx_rdy !== 1'b0) begin errors++; $display("FAIL park_rx_rdy got %b exp 0", rx_rdy); end
        tick;
        ext_oe = 4'b1111; ext_val = 4'b0101;
        #1;
        checks++; if (io !== 4'b0101) begin errors++; $display("FAIL turn_rx_z got %b exp 0101", io); end
        checks++; if (rx_rdy !== 1'b0) begin errors++; $display("FAIL turn_rx1_rx_rdy got %b exp 0", rx_rdy); end
        tick;
        checks++; if (rx_rdy !== 1'b0) begin errors++; $display("FAIL turn_rx2_rx_rdy got %b exp 0", rx_rdy); end
        checks++; if (in_data !== 4'b1111) begin errors++; $display("FAIL rx_sync_early got %b exp 1111", in_data); end
        tick;
        checks++; if (rx_rdy !== 1'b1) begin errors++; $display("FAIL release_rx_rdy got %b exp 1", rx_rdy); end
        checks++; if (in_data !== 4'b0101) begin errors++; $display("FAIL rx_in_data got %b exp 0101", in_data); end
        ext_oe = 4'b0000;
        #1;
    endtask

    task automatic test_open_drain;
        od_mode = 1'b1; oe_req = 1'b1; out_data = 4'b0110;
        tick; tick; tick;
        checks++; if (drv_gnt !== 1'b1) begin errors++; $display("FAIL od_grant got %b exp 1", drv_gnt); end
        checks++; if (io !== 4'b1111) begin errors++; $display("FAIL od_first_io got %b exp 1111", io); end
        tick;
        checks++; if (io !== 4'b0110) begin errors++; $display("FAIL od_io got %b exp 0110", io); end
        tick; tick;
        checks++; if (in_data !== 4'b0110) begin errors++; $display("FAIL od_in_data got %b exp 0110", in_data); end
        ext_oe = 4'b0110; ext_val = 4'b0000;
        #1;
        checks++; if (io !== 4'b0000) begin errors++; $display("FAIL od_released_bits got %b exp 0000", io); end
        ext_oe = 4'b0000;
        oe_req = 1'b0;
        tick;
        ext_oe = 4'b1111; ext_val = 4'b0000;
        #1;
        checks++; if (io !== 4'b0000) begin errors++; $display("FAIL od_park_released got %b exp 0000", io); end
        ext_oe = 4'b0000;
        tick; tick; tick;
        checks++; if (rx_rdy !== 1'b1) begin errors++; $display("FAIL od_back_rx got %b exp 1", rx_rdy); end
        od_mode = 1'b0;
    endtask

    task automatic test_abort;
        ext_oe3 = 4'b1111; ext_val3 = 4'b0000; oe_req3 = 1'b1;
        tick;
        checks++; if (rx_rdy3 !== 1'b0) begin errors++; $display("FAIL abort_turn1 got %b exp 0", rx_rdy3); end
        tick;
        checks++; if (rx_rdy3 !== 1'b0) begin errors++; $display("FAIL abort_turn2 got %b exp 0", rx_rdy3); end
        oe_req3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (rx_rdy3 !== 1'b1) begin errors++; $display("FAIL abort_rx cycle %0d got %b exp 1", i, rx_rdy3); end
            checks++; if (drv_gnt3 !== 1'b0) begin errors++; $display("FAIL abort_gnt cycle %0d got %b exp 0", i, drv_gnt3); end
            checks++; if (io3 !== 4'b0000) begin errors++; $display("FAIL abort_io cycle %0d got %b exp 0000", i, io3); end
        end
        ext_oe3 = 4'b0000;
    endtask

    task automatic test_back_to_back;
        oe_req = 1'b1; out_data = 4'b1100;
        tick; tick; tick;
        checks++; if (drv_gnt !== 1'b1) begin errors++; $display("FAIL b2b_first_grant got %b exp 1", drv_gnt); end
        oe_req = 1'b0;
        tick;
        oe_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            checks++; if (drv_gnt !== 1'b0) begin errors++; $display("FAIL b2b_gap edge %0d got %b exp 0", i, drv_gnt); end
            checks++; if (rx_rdy !== (i == 3)) begin errors++; $display("FAIL b2b_rx_rdy edge %0d got %b exp %b", i, rx_rdy, (i == 3)); end
        end
        tick;
        checks++; if (drv_gnt !== 1'b1) begin errors++; $display("FAIL b2b_regrant got %b exp 1", drv_gnt); end
        oe_req = 1'b0;
        tick; tick; tick; tick;
    endtask

    task automatic test_reset_mid_drive;
        oe_req = 1'b1; out_data = 4'b0000;
        tick; tick; tick; tick;
        checks++; if (io !== 4'b0000) begin errors++; $display("FAIL mid_drive_io got %b exp 0000", io); end
        rst = 1'b1;
        tick;
        checks++; if (io !== 4'b1111) begin errors++; $display("FAIL rst_release_io got %b exp 1111", io); end
        checks++; if (drv_gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt got %b exp 0", drv_gnt); end
        checks++; if (rx_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_no_park got %b exp 1", rx_rdy); end
        rst = 1'b0; oe_req = 1'b0;
        ext_oe = 4'b1111; ext_val = 4'b0000;
        #1;
        checks++; if (io !== 4'b0000) begin errors++; $display("FAIL rst_mid_z got %b exp 0000", io); end
        tick;
        checks++; if (rx_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_state_rx got %b exp 1", rx_rdy); end
        ext_oe = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_grant;
        test_release;
        test_open_drain;
        test_abort;
        test_back_to_back;
        test_reset_mid_drive;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_pad_bank.md
# sd_pad_bank

Parametrised, registered bidirectional pad bank for the SD host's CMD and DAT lines. It generalises the single-bit combinational bidirectional pad into a WIDTH-bit bank with registered output drive, multi-stage input synchronisation, a bus-turnaround state machine with request/grant handshake, and a per-transfer open-drain mode for the SD identification phase. It sits between the command/data engines and the top-level inout pins.

## Interface
Parameters:
- WIDTH, 1, number of lines in the bank (1 for CMD, 4 for DAT).
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.
- TURNAROUND, 2, high-Z cycles inserted on each direction change; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  bank clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- oe_req  in  1  engine requests to drive the lines.
- od_mode  in  1  1 = open-drain drive, 0 = push-pull; sampled every cycle.
- out_data  in  WIDTH  data to drive; sampled only while drv_gnt = 1.
- drv_gnt  out  1  lines are driven by this bank; out_data is being accepted.
- rx_rdy  out  1  bank is in receive state and in_data reflects the remote driver.
- in_data  out  WIDTH  synchronised line value.
- io  inout  WIDTH  pad lines.

## Operation
- States: RX, TURN_TX, DRIVE, PARK, TURN_RX. Reset state RX.
- RX: io all high-Z; rx_rdy = 1. oe_req = 1 -> TURN_TX, counter loaded with TURNAROUND-1.
- TURN_TX: io high-Z; count down; at 0 -> DRIVE. If oe_req drops before expiry -> RX directly (the lines were never driven).
- DRIVE: drv_gnt = 1; output register loaded with all ones on entry; every DRIVE cycle the output register takes out_data. oe_req = 0 -> PARK.
- PARK: exactly 1 cycle; output register forced to all ones and driven (push-pull) or released (open-drain); drv_gnt = 0 -> TURN_RX, counter loaded with TURNAROUND-1.
- TURN_RX: io high-Z; count down; at 0 -> RX. oe_req re-asserted here is ignored until RX is reached, then handled normally.
- Drive encoding per bit, with the enable asserted (DRIVE or PARK): push-pull drives the output register bit; open-drain drives 0 when the bit is 0, else high-Z. od_mode changes take effect on the next edge.
- Input synchroniser: a SYNC_STAGES-deep flop chain on io, always running (loopback visible while driving). in_data is the final stage.
- Counter width is 4 bits; no wrap is possible within the legal TURNAROUND range.

## Timing
- Reset values: drv_gnt = 0, rx_rdy = 1, output enable off (io high-Z), output register all ones, synchroniser stages all ones, in_data all ones.
- Latency from oe_req rising (sampled in RX) to drv_gnt = 1 is TURNAROUND+1 edges.
- out_data sampled at edge n (drv_gnt = 1) appears on io after edge n; the first DRIVE cycle drives all ones.
- Input latency: a change on io is visible on in_data SYNC_STAGES edges later.
- Release: oe_req falling sampled at edge n -> PARK after edge n, high-Z after edge n+1, rx_rdy = 1 after edge n+1+TURNAROUND.
- rst asserted in any state, including mid-DRIVE: at that edge all outputs take reset values and io is released. No PARK cycle is issued.
- oe_req and out_data are level signals; no other handshake exists. The engine must hold oe_req until drv_gnt is seen if it wants the line.

## Test plan
- Reset: drive rst for 2 edges while io is externally driven with 0 -> io from the bank is Z, drv_gnt = 0, rx_rdy = 1, in_data = all ones until SYNC_STAGES edges after rst release, then 0.
- Grant latency: WIDTH = 4, TURNAROUND = 2; raise oe_req -> drv_gnt = 1 exactly 3 edges later; io = 4'b1111 in the first DRIVE cycle; out_data = 4'b1010 -> io = 4'b1010 one edge later.
- Release: drop oe_req -> one PARK cycle with io = 4'b1111, then Z for 2 cycles, then rx_rdy = 1; external 4'b0101 -> in_data = 4'b0101 after 2 edges.
- Open-drain: od_mode = 1, out_data = 4'b0110 in DRIVE -> io bits 0 and 3 are driven 0, bits 1 and 2 are Z (pull-up reads 1); in_data = 4'b0110.
- Abort: oe_req high for 1 cycle in TURN_TX (TURNAROUND = 3) -> back to RX without drv_gnt ever asserting; io is never driven.
- Reset mid-DRIVE: assert rst while drv_gnt = 1 with io = 4'b0000 -> io is Z after that edge, no PARK cycle, and the state is RX.
